// File: rtl/lm07_spi_responder_if.sv
// lm07_spi_responder_if: SPI bus (CS/SCK/SIO) and host load/status signals
// of the LM07 sensor responder. The slave modport is the responder's view.
interface lm07_spi_responder_if;
    logic       CS;
    logic       SCK;
    logic       SIO;
    logic       SIO_OE;
    logic [7:0] temp_in;
    logic       temp_valid;
    logic       temp_ready;
    logic       busy;
    logic       frame_done;
    logic       frame_abort;
    logic [7:0] frame_count;

    modport slave (
        input  CS, SCK, temp_in, temp_valid,
        output SIO, SIO_OE, temp_ready, busy, frame_done, frame_abort, frame_count
    );

    modport master (
        output CS, SCK, temp_in, temp_valid,
        input  SIO, SIO_OE, temp_ready, busy, frame_done, frame_abort, frame_count
    );
endinterface

// File: rtl/lm07_spi_responder.sv
// lm07_spi_responder: emulates the LM07 temperature sensor on CS/SCK/SIO.
// A host loads a signed {sign, magnitude} value through a one-deep staging
// register; it only becomes the transmitted value between frames.
// Optional macro LM07_SYNC_EN: adds SYNC_STAGES-flop synchronizers on CS/SCK
// for an asynchronous master. Without it CS/SCK must share the SYSCLK domain.
module lm07_spi_responder #(
    parameter int         FRAME_BITS  = 16,
    parameter logic [7:0] TEMP_RESET  = 8'h19,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                SYSCLK,
    input  logic                RSTN,
    lm07_spi_responder_if.slave bus
);

`ifdef LM07_SYNC_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif
    localparam int SYNC_DEPTH = SYNC_ON ? SYNC_STAGES : 0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam int                    CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]      EDGE_FULL  = CNT_W'(FRAME_BITS);
    localparam logic [FRAME_BITS-1:0] RESET_WORD = FRAME_BITS'(TEMP_RESET) << (FRAME_BITS - 8);

    logic csNow, sckNow;
    logic csPrevQ, sckPrevQ;
    logic csFall, csRise, sckFall, sckRise;

    logic [0:0]            stateQ, stateD;
    logic [FRAME_BITS-1:0] shiftQ, shiftD, frameWord;
    logic [CNT_W-1:0]      edgeCntQ, edgeCntD;
    logic [7:0]            activeQ, activeD;
    logic [7:0]            stagedQ, stagedD;
    logic                  stagedFullQ, stagedFullD;
    logic [7:0]            frameCountQ, frameCountD;
    logic                  doneQ, doneD, abortQ, abortD;
    logic [6:0]            magSat;
    logic [7:0]            tempNorm;
    logic                  accept, commit;

    generate
        if (SYNC_DEPTH > 0) begin : g_sync
            logic [SYNC_DEPTH-1:0] csSyncQ, sckSyncQ;

            // Synchronizer chains; reset low so CS has to be seen high before a frame can start.
            always_ff @(posedge SYSCLK or negedge RSTN) begin
                if (!RSTN) begin
                    csSyncQ  <= '0;
                    sckSyncQ <= '0;
                end else begin
                    csSyncQ  <= (csSyncQ << 1) | SYNC_DEPTH'(bus.CS);
                    sckSyncQ <= (sckSyncQ << 1) | SYNC_DEPTH'(bus.SCK);
                end
            end

            assign csNow  = csSyncQ[SYNC_DEPTH-1];
            assign sckNow = sckSyncQ[SYNC_DEPTH-1];
        end else begin : g_direct
            assign csNow  = bus.CS;
            assign sckNow = bus.SCK;
        end
    endgenerate

    // Previous-value registers for edge detection; low after reset so a CS that is
    // already low (reset mid-frame) is not mistaken for a new frame start.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            csPrevQ  <= 1'b0;
            sckPrevQ <= 1'b0;
        end else begin
            csPrevQ  <= csNow;
            sckPrevQ <= sckNow;
        end
    end

    assign csFall  =  csPrevQ  & ~csNow;
    assign csRise  = ~csPrevQ  &  csNow;
    assign sckFall =  sckPrevQ & ~sckNow;
    assign sckRise = ~sckPrevQ &  sckNow;

    // Saturate magnitude to 99 and fold -0 into +0 before staging.
    always_comb begin
        magSat   = (bus.temp_in[6:0] > 7'd99) ? 7'd99 : bus.temp_in[6:0];
        tempNorm = {bus.temp_in[7] & (magSat != 7'd0), magSat};
    end

    // Word on the wire: the active temperature followed by zero padding.
    always_comb begin
        frameWord = '0;
        frameWord[FRAME_BITS-1 -: 8] = activeQ;
    end

    // Staging handshake: accept when empty, commit to active only while idle.
    always_comb begin
        accept      = bus.temp_valid && !stagedFullQ;
        commit      = stagedFullQ && (stateQ == ST_IDLE);
        activeD     = commit ? stagedQ : activeQ;
        stagedD     = stagedQ;
        stagedFullD = stagedFullQ;
        if (commit) begin
            stagedFullD = 1'b0;
        end
        if (accept) begin
            stagedFullD = 1'b1;
            stagedD     = tempNorm;
        end
    end

    // Frame FSM: reload while idle, shift on SCK falls and count SCK rises while CS is low.
    always_comb begin
        stateD      = stateQ;
        shiftD      = shiftQ;
        edgeCntD    = edgeCntQ;
        frameCountD = frameCountQ;
        doneD       = 1'b0;
        abortD      = 1'b0;
        case (stateQ)
            ST_IDLE: begin
                shiftD = frameWord;
                if (csFall) begin
                    stateD   = ST_SHIFT;
                    edgeCntD = '0;
                end
            end
            ST_SHIFT: begin
                if (csRise) begin
                    stateD = ST_IDLE;
                    if (edgeCntQ == EDGE_FULL) begin
                        doneD       = 1'b1;
                        frameCountD = frameCountQ + 8'd1;
                    end else begin
                        abortD = 1'b1;
                    end
                end else begin
                    if (sckFall) begin
                        shiftD = shiftQ << 1;
                    end
                    if (sckRise && (edgeCntQ != EDGE_FULL)) begin
                        edgeCntD = edgeCntQ + CNT_W'(1);
                    end
                end
            end
            default: begin
                stateD = ST_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            stateQ      <= ST_IDLE;
            shiftQ      <= RESET_WORD;
            edgeCntQ    <= '0;
            activeQ     <= TEMP_RESET;
            stagedQ     <= '0;
            stagedFullQ <= 1'b0;
            frameCountQ <= '0;
            doneQ       <= 1'b0;
            abortQ      <= 1'b0;
        end else begin
            stateQ      <= stateD;
            shiftQ      <= shiftD;
            edgeCntQ    <= edgeCntD;
            activeQ     <= activeD;
            stagedQ     <= stagedD;
            stagedFullQ <= stagedFullD;
            frameCountQ <= frameCountD;
            doneQ       <= doneD;
            abortQ      <= abortD;
        end
    end

    assign bus.SIO         = shiftQ[FRAME_BITS-1];
    assign bus.SIO_OE      = (stateQ == ST_SHIFT);
    assign bus.busy        = (stateQ == ST_SHIFT);
    assign bus.temp_ready  = !stagedFullQ;
    assign bus.frame_done  = doneQ;
    assign bus.frame_abort = abortQ;
    assign bus.frame_count = frameCountQ;

endmodule

// File: tb/tb_lm07_spi_responder.sv
// tb_lm07_spi_responder: drives the responder like the LM07 reader (SCK =
// SYSCLK/2 toggled on SYSCLK negedge) and compares the received bits, pulses
// and counters against a value-level model of the sensor.
module tb_lm07_spi_responder;
    localparam int         FRAME_BITS = 16;
    localparam logic [7:0] TEMP_RESET = 8'h19;

    logic SYSCLK;
    logic RSTN;

    lm07_spi_responder_if bus();

    lm07_spi_responder #(
        .FRAME_BITS (FRAME_BITS),
        .TEMP_RESET (TEMP_RESET),
        .SYNC_STAGES(2)
    ) dut (
        .SYSCLK(SYSCLK),
        .RSTN  (RSTN),
        .bus   (bus)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Sensor model: value on the wire, one pending value, completed frame count.
    logic [7:0] mActive;
    logic [7:0] mPendingVal;
    bit         mPending;
    logic [7:0] mCount;

    logic [31:0] rxBits;
    int          rxCount;

    // Clock generation.
    initial begin
        SYSCLK = 1'b0;
        forever #5 SYSCLK = ~SYSCLK;
    end

    // Time limit so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] norm(input logic [7:0] v);
        int mag;
        mag = int'(v[6:0]);
        if (mag > 99) mag = 99;
        if (v[7] && mag != 0) return 8'(128 + mag);
        return 8'(mag);
    endfunction

    function automatic logic [31:0] expected_rx(input logic [7:0] val, input int n);
        logic [31:0] acc;
        int          b;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            b   = (i < 8) ? ((int'(val) >> (7 - i)) & 1) : 0;
            acc = (acc << 1) | 32'(b);
        end
        return acc;
    endfunction

    task automatic model_reset();
        mActive     = TEMP_RESET;
        mPending    = 0;
        mPendingVal = '0;
        mCount      = '0;
    endtask

    task automatic model_load(input logic [7:0] v, input bit inFrame);
        if (!mPending) begin
            if (inFrame) begin
                mPending    = 1;
                mPendingVal = norm(v);
            end else begin
                mActive = norm(v);
            end
        end
    endtask

    task automatic model_frame_end(input int n);
        if (n >= FRAME_BITS) mCount = 8'((int'(mCount) + 1) % 256);
        if (mPending) begin
            mActive  = mPendingVal;
            mPending = 0;
        end
    endtask

    task automatic cs_low();
        @(negedge SYSCLK);
        bus.CS  = 1'b0;
        rxBits  = '0;
        rxCount = 0;
        @(negedge SYSCLK);
    endtask

    task automatic sck_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge SYSCLK);
            rxBits  = {rxBits[30:0], bus.SIO};
            rxCount = rxCount + 1;
            bus.SCK = 1'b1;
            @(negedge SYSCLK);
            bus.SCK = 1'b0;
        end
    endtask

    task automatic cs_high(output int nDone, output int nAbort);
        @(negedge SYSCLK);
        bus.CS = 1'b1;
        nDone  = 0;
        nAbort = 0;
        repeat (4) begin
            @(posedge SYSCLK);
            #1;
            if (bus.frame_done  === 1'b1) nDone++;
            if (bus.frame_abort === 1'b1) nAbort++;
        end
    endtask

    task automatic run_frame(input int n, output int nDone, output int nAbort);
        cs_low();
        sck_edges(n);
        cs_high(nDone, nAbort);
    endtask

    task automatic load(input logic [7:0] v, output logic acc, output logic r1, output logic r2);
        @(negedge SYSCLK);
        bus.temp_in    = v;
        bus.temp_valid = 1'b1;
        acc = bus.temp_ready;
        @(negedge SYSCLK);
        bus.temp_valid = 1'b0;
        r1 = bus.temp_ready;
        @(negedge SYSCLK);
        r2 = bus.temp_ready;
    endtask

    task automatic test_reset();
        bus.CS = 1'b1; bus.SCK = 1'b0; bus.temp_valid = 1'b0; bus.temp_in = '0;
        RSTN = 1'b1;
        #2 RSTN = 1'b0;
        model_reset();
        repeat (3) @(negedge SYSCLK);
        #1;
        nCompared++; if (bus.SIO !== TEMP_RESET[7]) begin nMismatched++; $display("[TB] FAIL reset_sio: got %b required %b", bus.SIO, TEMP_RESET[7]); end
        nCompared++; if (bus.SIO_OE !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_sio_oe: got %b required 0", bus.SIO_OE); end
        nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b required 0", bus.busy); end
        nCompared++; if (bus.temp_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b required 1", bus.temp_ready); end
        nCompared++; if (bus.frame_done !== 1'b0 || bus.frame_abort !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_pulses: got done=%b abort=%b required 0/0", bus.frame_done, bus.frame_abort); end
        nCompared++; if (bus.frame_count !== mCount) begin nMismatched++; $display("[TB] FAIL reset_count: got %0d required %0d", bus.frame_count, mCount); end
        @(negedge SYSCLK);
        RSTN = 1'b1;
        repeat (3) @(negedge SYSCLK);
        nCompared++; if (bus.SIO !== mActive[7] || bus.temp_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL post_reset_idle: got sio=%b ready=%b required %b/1", bus.SIO, bus.temp_ready, mActive[7]); end
    endtask

    task automatic test_default_frame();
        logic [7:0] expVal;
        int nDone, nAbort;
        expVal = mActive;
        cs_low();
        sck_edges(8);
        nCompared++; if (bus.busy !== 1'b1 || bus.SIO_OE !== 1'b1) begin nMismatched++; $display("[TB] FAIL frame_busy: got busy=%b oe=%b required 1/1", bus.busy, bus.SIO_OE); end
        sck_edges(8);
        cs_high(nDone, nAbort);
        model_frame_end(16);
        nCompared++; if (rxBits !== expected_rx(expVal, 16)) begin nMismatched++; $display("[TB] FAIL default_bits: got %h required %h", rxBits, expected_rx(expVal, 16)); end
        nCompared++; if (nDone !== 1 || nAbort !== 0) begin nMismatched++; $display("[TB] FAIL default_pulses: got done=%0d abort=%0d required 1/0", nDone, nAbort); end
        nCompared++; if (bus.frame_count !== mCount) begin nMismatched++; $display("[TB] FAIL default_count: got %0d required %0d", bus.frame_count, mCount); end
        nCompared++; if (bus.busy !== 1'b0 || bus.SIO_OE !== 1'b0) begin nMismatched++; $display("[TB] FAIL default_idle: got busy=%b oe=%b required 0/0", bus.busy, bus.SIO_OE); end
    endtask

    task automatic test_idle_load(input logic [7:0] v, input int n, input string tag);
        logic acc, r1, r2;
        logic expAcc;
        int   nDone, nAbort, expDone;
        expAcc = !mPending;
        load(v, acc, r1, r2);
        model_load(v, 0);
        nCompared++; if (acc !== expAcc || r1 !== 1'b0 || r2 !== 1'b1) begin nMismatched++; $display("[TB] FAIL %s_ready: got acc=%b r1=%b r2=%b required %b/0/1", tag, acc, r1, r2, expAcc); end
        run_frame(n, nDone, nAbort);
        expDone = (n >= FRAME_BITS) ? 1 : 0;
        model_frame_end(n);
        nCompared++; if (rxBits !== expected_rx(mActive, n)) begin nMismatched++; $display("[TB] FAIL %s_bits: got %h required %h (n=%0d)", tag, rxBits, expected_rx(mActive, n), n); end
        nCompared++; if (nDone !== expDone || nAbort !== 1 - expDone) begin nMismatched++; $display("[TB] FAIL %s_pulses: got done=%0d abort=%0d required %0d/%0d", tag, nDone, nAbort, expDone, 1 - expDone); end
        nCompared++; if (bus.frame_count !== mCount) begin nMismatched++; $display("[TB] FAIL %s_count: got %0d required %0d", tag, bus.frame_count, mCount); end
    endtask

    task automatic test_mid_frame_load();
        logic [7:0] expVal;
        logic acc, r1, r2, expAcc;
        int nDone, nAbort;
        expVal = mActive;
        cs_low();
        sck_edges(4);
        expAcc = !mPending;
        load(8'h0A, acc, r1, r2);
        model_load(8'h0A, 1);
        nCompared++; if (acc !== expAcc || r1 !== 1'b0 || r2 !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_accept: got acc=%b r1=%b r2=%b required %b/0/0", acc, r1, r2, expAcc); end
        sck_edges(4);
        expAcc = !mPending;
        load(8'h0B, acc, r1, r2);
        model_load(8'h0B, 1);
        nCompared++; if (acc !== expAcc) begin nMismatched++; $display("[TB] FAIL mid_refuse: got acc=%b required %b", acc, expAcc); end
        sck_edges(8);
        cs_high(nDone, nAbort);
        nCompared++; if (rxBits !== expected_rx(expVal, 16)) begin nMismatched++; $display("[TB] FAIL mid_old_bits: got %h required %h", rxBits, expected_rx(expVal, 16)); end
        model_frame_end(16);
        nCompared++; if (bus.temp_ready !== !mPending) begin nMismatched++; $display("[TB] FAIL mid_ready_after: got %b required %b", bus.temp_ready, !mPending); end
        run_frame(16, nDone, nAbort);
        model_frame_end(16);
        nCompared++; if (rxBits !== expected_rx(mActive, 16)) begin nMismatched++; $display("[TB] FAIL mid_new_bits: got %h required %h", rxBits, expected_rx(mActive, 16)); end
        nCompared++; if (bus.frame_count !== mCount) begin nMismatched++; $display("[TB] FAIL mid_count: got %0d required %0d", bus.frame_count, mCount); end
    endtask

    task automatic test_abort();
        logic [7:0] expVal;
        int nDone, nAbort;
        expVal = mActive;
        run_frame(9, nDone, nAbort);
        model_frame_end(9);
        nCompared++; if (nDone !== 0 || nAbort !== 1) begin nMismatched++; $display("[TB] FAIL abort_pulses: got done=%0d abort=%0d required 0/1", nDone, nAbort); end
        nCompared++; if (bus.frame_count !== mCount) begin nMismatched++; $display("[TB] FAIL abort_count: got %0d required %0d", bus.frame_count, mCount); end
        nCompared++; if (rxBits !== expected_rx(expVal, 9)) begin nMismatched++; $display("[TB] FAIL abort_bits: got %h required %h", rxBits, expected_rx(expVal, 9)); end
        run_frame(16, nDone, nAbort);
        model_frame_end(16);
        nCompared++; if (rxBits !== expected_rx(mActive, 16)) begin nMismatched++; $display("[TB] FAIL abort_restart_bits: got %h required %h", rxBits, expected_rx(mActive, 16)); end
    endtask

    task automatic test_reset_mid_frame();
        int nDone, nAbort;
        cs_low();
        sck_edges(5);
        @(negedge SYSCLK);
        RSTN = 1'b0;
        @(negedge SYSCLK);
        RSTN = 1'b1;
        model_reset();
        sck_edges(3);
        nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_mid_busy: got %b required 0", bus.busy); end
        cs_high(nDone, nAbort);
        nCompared++; if (nDone !== 0 || nAbort !== 0) begin nMismatched++; $display("[TB] FAIL rst_mid_pulses: got done=%0d abort=%0d required 0/0", nDone, nAbort); end
        run_frame(16, nDone, nAbort);
        model_frame_end(16);
        nCompared++; if (rxBits !== expected_rx(mActive, 16)) begin nMismatched++; $display("[TB] FAIL rst_mid_bits: got %h required %h", rxBits, expected_rx(mActive, 16)); end
        nCompared++; if (bus.frame_count !== mCount) begin nMismatched++; $display("[TB] FAIL rst_mid_count: got %0d required %0d", bus.frame_count, mCount); end
    endtask

    task automatic test_random();
        logic [7:0] v;
        int n;
        for (int k = 0; k < 8; k++) begin
            v = 8'($urandom);
            n = (k % 2 == 0) ? FRAME_BITS : int'($urandom_range(1, 20));
            test_idle_load(v, n, "random");
        end
    endtask

    initial begin
        test_reset();
        test_default_frame();
        test_idle_load(8'hE4, 16, "saturate");
        test_idle_load(8'h80, 16, "neg_zero");
        test_mid_frame_load();
        test_abort();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/lm07_spi_responder.md
# lm07_spi_responder

Synthesizable SPI responder that emulates the LM07 temperature sensor on the CS/SCK/SIO bus, for bench loopback against the LM07 reader and for board-level sensor substitution. A host loads a signed temperature via valid/ready handshake; the block serialises it MSB-first on SIO during each CS-low frame. The next value is staged and committed only between frames, so a frame never mixes two values.

## Interface
- FRAME_BITS, 16: bits per frame; must be ≥ 8.
- TEMP_RESET, 8'h19: active value after reset ({sign, magnitude}), +25 °C.
- SYNC_STAGES, 2: synchronizer depth on CS/SCK; used only with LM07_SYNC_EN.

- SYSCLK  in  1  system clock; all state on posedge.
- RSTN  in  1  reset, asynchronous, active-low.
- CS  in  1  chip select from reader, active-low.
- SCK  in  1  serial clock from reader; reader samples SIO on SCK rising edge.
- SIO  out  1  serial data to reader.
- SIO_OE  out  1  high while frame active (CS low); for external tri-state.
- temp_in  in  8  bit7 sign (1 = negative), bits6:0 magnitude in °C.
- temp_valid  in  1  host offers temp_in.
- temp_ready  out  1  staging register empty.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse: CS rose after ≥ FRAME_BITS SCK rising edges.
- frame_abort  out  1  one-cycle pulse: CS rose after fewer rising edges.
- frame_count  out  8  completed frames, wraps 255→0.

## Operation
- Frame word = {sign, mag[6:0], (FRAME_BITS-8)'b0}.
- Acceptance: temp_valid && temp_ready on a posedge writes staging. Magnitude >99 saturates to 99. Sign with magnitude 0 is normalised to +0.
- Commit: when staging is full and the block is IDLE, staging moves to active and temp_ready returns high on the next cycle. A value accepted while a frame runs waits for CS high. A second value is refused until then because temp_ready is low.
- States:
  - IDLE: shift register reloaded from active word every cycle. SIO = word MSB, so bit FRAME_BITS-1 is valid before the first SCK rise. SIO_OE = 0.
  - IDLE→SHIFT on detected CS low: shift register frozen, bit and edge counters cleared, busy = 1, SIO_OE = 1.
  - SHIFT: each detected SCK falling edge shifts left and inserts 0. Each detected rising edge increments the edge counter, which saturates at FRAME_BITS. After all bits are out, SIO = 0.
  - SHIFT→IDLE on detected CS high: pulse frame_done (edge count = FRAME_BITS, frame_count += 1) or frame_abort (otherwise); busy = 0.
- Simultaneous events:
  - CS low and SCK fall detected in the same cycle: load the word, no shift.
  - CS high and SCK edge in the same cycle: ignore the edge.
  - Commit and acceptance in the same cycle: the committed value goes active and the new one goes to staging.
- SCK edges while CS is high are ignored.

## Timing
- Reset values:
  - Active word = TEMP_RESET; staging empty; temp_ready = 1.
  - SIO = TEMP_RESET[7]; SIO_OE = 0; busy = 0.
  - frame_done = frame_abort = 0; frame_count = 0.
- RSTN asserted mid-frame: immediate return to reset state. The remainder of that frame is ignored until CS is seen high, then low again.
- Without LM07_SYNC_EN:
  - CS/SCK are registered once; edge = registered vs previous.
  - SIO updates at the first posedge after an SCK fall.
  - Supports SCK = SYSCLK/2 toggled on SYSCLK negedge, as generated by the reader.
- With LM07_SYNC_EN: detection latency is SYNC_STAGES+1 cycles. SCK high and low phases must each be ≥ SYNC_STAGES+2 SYSCLK periods.
- frame_done/frame_abort assert one cycle after CS-high detection.

## Configuration
- LM07_SYNC_EN defined: CS and SCK pass through SYNC_STAGES-flop synchronizers, for an asynchronous external master.
- LM07_SYNC_EN undefined: single sampling register per input; same-clock-domain use only.

## Test plan
- Reset, no load, one 16-edge frame -> SIO bits 0,0,0,1,1,0,0,1 then eight 0s; frame_done pulse; frame_count = 1.
- Load 8'hE4 (−100) while idle, one frame -> saturated word 8'hE3 (−99) shifted first; temp_ready low one cycle, then high.
- Load 8'h80 (−0) -> transmitted as 8'h00.
- Load 8'h0A mid-frame -> current frame keeps old value; temp_ready low until CS high; next frame sends 8'h0A. Load 8'h0B attempted before CS high -> refused (temp_ready = 0).
- CS high after 9 rising edges -> frame_abort pulse; frame_count unchanged; next full frame restarts at the MSB.
- RSTN pulse after 5 edges, then full frame -> TEMP_RESET word sent; frame_count = 1.
